// File: rtl/op_code.sv
// 3-bit to 8-line one-hot opcode decoder with registered outputs, valid and change-detect strobes.
// Optional per-opcode saturating usage counters are enabled by defining OP_CODE_STATS_EN.
module op_code (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       A,
    input  logic       B,
    input  logic       C,
`ifdef OP_CODE_STATS_EN
    input  logic [2:0] sel,
    output logic [7:0] count,
`endif
    output logic [7:0] opCode,
    output logic       valid,
    output logic       changed
);

    typedef enum logic {
        LAST_EMPTY,
        LAST_LOADED
    } last_state_t;

    last_state_t last_state;
    logic [2:0]  last_code;
    logic [2:0]  code;
    logic [7:0]  onehot;
    logic        differs;

    always_comb begin
        code    = {A, B, C};
        onehot  = 8'(1) << code;
        differs = (last_state == LAST_EMPTY) || (code != last_code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCode     <= '0;
            valid      <= 1'b0;
            changed    <= 1'b0;
            last_code  <= '0;
            last_state <= LAST_EMPTY;
        end else if (en) begin
            opCode     <= onehot;
            valid      <= 1'b1;
            changed    <= differs;
            last_code  <= code;
            last_state <= LAST_LOADED;
        end else begin
            valid      <= 1'b0;
            changed    <= 1'b0;
        end
    end

`ifdef OP_CODE_STATS_EN
    logic [7:0] counters [8];

    // Counters stick at 8'hFF rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                counters[i] <= '0;
            end
        end else if (en && (counters[code] != 8'hFF)) begin
            counters[code] <= counters[code] + 8'd1;
        end
    end

    always_comb begin
        count = counters[sel];
    end
`endif

endmodule

// File: tb/tb_op_code.sv
// Directed self-checking bench for op_code; stats scenarios run only when OP_CODE_STATS_EN is defined.
module tb_op_code;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       A;
    logic       B;
    logic       C;
    logic [7:0] opCode;
    logic       valid;
    logic       changed;
`ifdef OP_CODE_STATS_EN
    logic [2:0] sel;
    logic [7:0] count;
`endif

    int checks;
    int errors;

    op_code dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .A       (A),
        .B       (B),
        .C       (C),
`ifdef OP_CODE_STATS_EN
        .sel     (sel),
        .count   (count),
`endif
        .opCode  (opCode),
        .valid   (valid),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] c);
        en = e;
        {A, B, C} = c;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(1'b0, 3'b000);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (opCode !== 8'h00 || valid !== 1'b0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: opCode=%h valid=%b changed=%b, expected 00 0 0",
                     opCode, valid, changed);
        end
`ifdef OP_CODE_STATS_EN
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            checks++;
            if (count !== 8'h00) begin
                errors++;
                $display("FAIL reset_count sel=%0d: count=%h, expected 00", i, count);
            end
        end
`endif
    endtask

    task automatic test_sweep;
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i));
            tick();
            checks++;
            if (opCode !== exp_tab[i] || valid !== 1'b1 || changed !== 1'b1) begin
                errors++;
                $display("FAIL sweep code=%0d: opCode=%h valid=%b changed=%b, expected %h 1 1",
                         i, opCode, valid, changed, exp_tab[i]);
            end
        end
    endtask

    task automatic test_hold_repeat;
        drive(1'b1, 3'b101);
        tick();
        checks++;
        if (opCode !== 8'h20 || valid !== 1'b1 || changed !== 1'b1) begin
            errors++;
            $display("FAIL hold_first: opCode=%h valid=%b changed=%b, expected 20 1 1",
                     opCode, valid, changed);
        end
        drive(1'b0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (opCode !== 8'h20 || valid !== 1'b0 || changed !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle cycle=%0d: opCode=%h valid=%b changed=%b, expected 20 0 0",
                         i, opCode, valid, changed);
            end
        end
        drive(1'b1, 3'b101);
        tick();
        checks++;
        if (opCode !== 8'h20 || valid !== 1'b1 || changed !== 1'b0) begin
            errors++;
            $display("FAIL hold_repeat: opCode=%h valid=%b changed=%b, expected 20 1 0",
                     opCode, valid, changed);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] codes [4];
        logic [7:0] exp_op [4];
        logic       exp_ch [4];
        codes  = '{3'b101, 3'b011, 3'b011, 3'b000};
        exp_op = '{8'h20, 8'h08, 8'h08, 8'h01};
        exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, codes[i]);
            tick();
            checks++;
            if (opCode !== exp_op[i] || valid !== 1'b1 || changed !== exp_ch[i]) begin
                errors++;
                $display("FAIL back_to_back step=%0d: opCode=%h valid=%b changed=%b, expected %h 1 %b",
                         i, opCode, valid, changed, exp_op[i], exp_ch[i]);
            end
        end
        drive(1'b0, 3'b000);
        tick();
    endtask

    task automatic test_async_reset;
        drive(1'b1, 3'b111);
        tick();
        checks++;
        if (opCode !== 8'h80) begin
            errors++;
            $display("FAIL async_pre: opCode=%h, expected 80", opCode);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (opCode !== 8'h00 || valid !== 1'b0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL async_immediate: opCode=%h valid=%b changed=%b, expected 00 0 0",
                     opCode, valid, changed);
        end
        tick();
        checks++;
        if (opCode !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL async_held: opCode=%h valid=%b, expected 00 0", opCode, valid);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (opCode !== 8'h80 || valid !== 1'b1 || changed !== 1'b1) begin
            errors++;
            $display("FAIL async_after: opCode=%h valid=%b changed=%b, expected 80 1 1",
                     opCode, valid, changed);
        end
        drive(1'b0, 3'b000);
    endtask

`ifdef OP_CODE_STATS_EN
    task automatic test_stats_saturation;
        do_reset();
        drive(1'b1, 3'b011);
        repeat (300) tick();
        drive(1'b0, 3'b000);
        sel = 3'd3;
        #1;
        checks++;
        if (count !== 8'hFF) begin
            errors++;
            $display("FAIL stats_sat sel=3: count=%h, expected ff", count);
        end
        sel = 3'd0;
        #1;
        checks++;
        if (count !== 8'h00) begin
            errors++;
            $display("FAIL stats_sat sel=0: count=%h, expected 00", count);
        end
    endtask

    task automatic test_stats_accum;
        do_reset();
        sel = 3'd6;
        drive(1'b1, 3'b110);
        repeat (5) tick();
        checks++;
        if (count !== 8'd5) begin
            errors++;
            $display("FAIL stats_accum sel=6: count=%0d, expected 5", count);
        end
        drive(1'b1, 3'b001);
        repeat (2) tick();
        drive(1'b0, 3'b000);
        tick();
        sel = 3'd1;
        #1;
        checks++;
        if (count !== 8'd2) begin
            errors++;
            $display("FAIL stats_accum sel=1: count=%0d, expected 2", count);
        end
        sel = 3'd6;
        #1;
        checks++;
        if (count !== 8'd5) begin
            errors++;
            $display("FAIL stats_accum_hold sel=6: count=%0d, expected 5", count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 3'b000);
`ifdef OP_CODE_STATS_EN
        sel = 3'd0;
`endif
        test_reset();
        test_sweep();
        test_hold_repeat();
        test_back_to_back();
        test_async_reset();
`ifdef OP_CODE_STATS_EN
        test_stats_saturation();
        test_stats_accum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
